// File: rtl/split_target_mem.sv
// Memory-backed bus target with posted writes and optional split-transaction reads.
// One transaction is in flight at a time; a new address is only accepted in IDLE.
module split_target_mem #(
  parameter logic [3:0] BASE_ID       = 4'h1,
  parameter bit         SPLIT_EN      = 1'b1,
  parameter int         SPLIT_LATENCY = 8,
  parameter int         WDATA_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] target_addr_in,
  input  logic        target_addr_in_valid,
  input  logic [7:0]  target_data_in,
  input  logic        target_data_in_valid,
  input  logic        bus_rw,
  input  logic        split_grant,
  output logic [7:0]  target_data_out,
  output logic        target_data_out_valid,
  output logic        target_rw,
  output logic        target_ready,
  output logic        target_ack,
  output logic        target_split_ack,
  output logic        split_req
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE, WAIT_WDATA, READ, SPLIT_WAIT, SPLIT_REQ, SEND
  } state_t;

  state_t                    r_state;
  logic [7:0]                r_cnt;
  logic [11:0]               r_addr;
  logic signed [DATA_W-1:0]  r_mem [4096];
  logic [DATA_W-1:0]         r_data_out;
  logic                      r_valid;
  logic                      r_ack;
  logic                      r_split_ack;
  logic                      r_split_req;

  logic                      w_accept;
  logic                      w_wr;
  logic [DATA_W-1:0]         w_rd_data;

  assign w_accept  = (r_state == IDLE) && target_addr_in_valid &&
                     (target_addr_in[15:12] == BASE_ID);
  assign w_wr      = (r_state == WAIT_WDATA) && target_data_in_valid;
  assign w_rd_data = r_mem[r_addr];

  // Address latch and storage array carry no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_addr <= target_addr_in[11:0];
    if (w_wr)
      r_mem[r_addr] <= target_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_data_out  <= 8'h00;
      r_valid     <= 1'b0;
      r_ack       <= 1'b0;
      r_split_ack <= 1'b0;
      r_split_req <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_ack       <= 1'b0;
      r_split_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (bus_rw) begin
              r_state <= WAIT_WDATA;
              r_cnt   <= 8'(WDATA_TIMEOUT);
            end else if (SPLIT_EN) begin
              r_state     <= SPLIT_WAIT;
              r_split_ack <= 1'b1;
              r_cnt       <= 8'(SPLIT_LATENCY);
            end else begin
              r_state <= READ;
            end
          end
        end
        WAIT_WDATA: begin
          if (target_data_in_valid) begin
            r_ack   <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= IDLE;
          end else if (r_cnt <= 8'd1) begin
            r_cnt   <= 8'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        READ: begin
          r_data_out <= w_rd_data;
          r_valid    <= 1'b1;
          r_ack      <= 1'b1;
          r_state    <= IDLE;
        end
        SPLIT_WAIT: begin
          // Count reaching zero on this edge makes split_req visible SPLIT_LATENCY
          // cycles after target_split_ack.
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt <= 8'd1) begin
            r_cnt       <= 8'd0;
            r_data_out  <= w_rd_data;
            r_split_req <= 1'b1;
            r_state     <= SPLIT_REQ;
          end
        end
        SPLIT_REQ: begin
          if (split_grant) begin
            r_split_req <= 1'b0;
            r_valid     <= 1'b1;
            r_ack       <= 1'b1;
            r_state     <= SEND;
          end
        end
        SEND: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign target_data_out       = r_data_out;
  assign target_data_out_valid = r_valid;
  assign target_ack            = r_ack;
  assign target_split_ack      = r_split_ack;
  assign split_req             = r_split_req;
  assign target_ready          = (r_state == IDLE);
  assign target_rw             = bus_rw;

endmodule

// File: tb/tb_split_target_mem.sv
// Bench for split_target_mem: transaction-level model compared every cycle, plus
// directed vectors with hand-computed timing and data expectations.
module tb_split_target_mem;
  localparam int L = 8;
  localparam int T = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] addr = '0;
  logic        av = 1'b0, dv = 1'b0, rw = 1'b0, grant = 1'b0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        dov, trw, trdy, tack, tsack, sreq;

  logic [15:0] b_addr = '0;
  logic        b_av = 1'b0, b_dv = 1'b0, b_rw = 1'b0;
  logic [7:0]  b_din = '0;
  logic [7:0]  b_dout;
  logic        b_dov, b_trw, b_trdy, b_tack, b_tsack, b_sreq;

  split_target_mem #(.BASE_ID(4'h1), .SPLIT_EN(1'b1), .SPLIT_LATENCY(L), .WDATA_TIMEOUT(T)) u_dut (
    .clk(clk), .rst(rst), .target_addr_in(addr), .target_addr_in_valid(av),
    .target_data_in(din), .target_data_in_valid(dv), .bus_rw(rw), .split_grant(grant),
    .target_data_out(dout), .target_data_out_valid(dov), .target_rw(trw),
    .target_ready(trdy), .target_ack(tack), .target_split_ack(tsack), .split_req(sreq));

  split_target_mem #(.BASE_ID(4'h1), .SPLIT_EN(1'b0), .SPLIT_LATENCY(L), .WDATA_TIMEOUT(T)) u_imm (
    .clk(clk), .rst(rst), .target_addr_in(b_addr), .target_addr_in_valid(b_av),
    .target_data_in(b_din), .target_data_in_valid(b_dv), .bus_rw(b_rw), .split_grant(1'b0),
    .target_data_out(b_dout), .target_data_out_valid(b_dov), .target_rw(b_trw),
    .target_ready(b_trdy), .target_ack(b_tack), .target_split_ack(b_tsack), .split_req(b_sreq));

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending transaction with absolute edge deadlines.
  typedef enum {P_NONE, P_WR, P_SPL, P_REQ, P_SEND} pend_t;
  pend_t      pend = P_NONE;
  logic [7:0] m_mem [4096];
  logic [11:0] m_a = '0;
  longint     cyc = 0, m_deadline = 0, m_req_at = 0;
  logic       e_valid = 0, e_ack = 0, e_sack = 0, e_req = 0, e_ready = 1;
  logic [7:0] e_data = 8'h00;

  task automatic model_step();
    e_valid = 0; e_ack = 0; e_sack = 0;
    if (rst) begin
      pend = P_NONE; e_req = 0; e_data = 8'h00;
    end else begin
      case (pend)
        P_NONE: if (av && addr[15:12] == 4'h1) begin
          m_a = addr[11:0];
          if (rw) begin pend = P_WR; m_deadline = cyc + T; end
          else begin pend = P_SPL; e_sack = 1; m_req_at = cyc + L; end
        end
        P_WR: if (dv) begin
          m_mem[m_a] = din; e_ack = 1; pend = P_NONE;
        end else if (cyc == m_deadline) pend = P_NONE;
        P_SPL: if (cyc == m_req_at) begin
          e_data = m_mem[m_a]; e_req = 1; pend = P_REQ;
        end
        P_REQ: if (grant) begin
          e_req = 0; e_valid = 1; e_ack = 1; pend = P_SEND;
        end
        P_SEND: pend = P_NONE;
        default: pend = P_NONE;
      endcase
    end
    e_ready = (pend == P_NONE);
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    #2;
    chk("data_out", dout, e_data);
    chk("data_out_valid", dov, e_valid);
    chk("ack", tack, e_ack);
    chk("split_ack", tsack, e_sack);
    chk("split_req", sreq, e_req);
    chk("ready", trdy, e_ready);
    chk("target_rw", trw, rw);
  end

  task automatic strobe_addr(input logic [15:0] a, input logic w);
    @(negedge clk); addr = a; rw = w; av = 1'b1;
    @(negedge clk); av = 1'b0;
  endtask

  task automatic strobe_data(input logic [7:0] d);
    @(negedge clk); din = d; dv = 1'b1;
    @(negedge clk); dv = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (!sreq && k < 2 * L + 4) begin @(negedge clk); k++; end
    chk(nm, sreq, 1'b1);
  endtask

  task automatic split_read(input logic [15:0] a, input logic [7:0] exp, input string nm);
    strobe_addr(a, 1'b0);
    wait_req({nm, "_req"});
    @(negedge clk); grant = 1'b1;
    @(negedge clk); grant = 1'b0;
    chk({nm, "_valid"}, dov, 1'b1);
    chk({nm, "_data"}, dout, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", trdy, 1'b1);
    chk("reset_data", dout, 8'h00);
    chk("reset_req", sreq, 1'b0);
    rst = 1'b0;

    // Write 0x1005 <- A5, data three cycles after the address.
    strobe_addr(16'h1005, 1'b1);
    chk("wr_not_ready", trdy, 1'b0);
    repeat (2) @(negedge clk);
    strobe_data(8'hA5);
    chk("wr_ack", tack, 1'b1);
    chk("wr_ready", trdy, 1'b1);

    // Split read with exact timing.
    strobe_addr(16'h1005, 1'b0);
    chk("split_ack_p1", tsack, 1'b1);
    for (int n = 1; n <= L; n++) begin
      @(negedge clk);
      chk("split_req_lat", sreq, (n == L));
    end
    repeat (5) begin
      @(negedge clk);
      chk("split_req_hold", sreq, 1'b1);
    end
    grant = 1'b1;
    @(negedge clk); grant = 1'b0;
    chk("send_valid", dov, 1'b1);
    chk("send_data", dout, 8'hA5);
    chk("send_ack", tack, 1'b1);
    chk("send_req_low", sreq, 1'b0);
    @(negedge clk);
    chk("send_valid_1cyc", dov, 1'b0);
    chk("data_hold", dout, 8'hA5);

    // Foreign target id is ignored.
    strobe_addr(16'h2005, 1'b1);
    chk("foreign_ready", trdy, 1'b1);
    chk("foreign_sack", tsack, 1'b0);
    strobe_data(8'h11);
    chk("foreign_ack", tack, 1'b0);

    // Grant outside SPLIT_REQ is ignored.
    @(negedge clk); grant = 1'b1;
    @(negedge clk); grant = 1'b0;
    chk("stray_grant_valid", dov, 1'b0);

    // Write-data timeout; a late strobe leaves memory unchanged.
    strobe_addr(16'h1005, 1'b1);
    repeat (T - 1) @(negedge clk);
    chk("timeout_busy", trdy, 1'b0);
    @(negedge clk);
    chk("timeout_idle", trdy, 1'b1);
    chk("timeout_no_ack", tack, 1'b0);
    strobe_data(8'h3C);
    chk("late_data_ack", tack, 1'b0);
    split_read(16'h1005, 8'hA5, "after_timeout");

    // Data strobe coincident with address is ignored.
    @(negedge clk); addr = 16'h1010; rw = 1'b1; av = 1'b1; din = 8'h77; dv = 1'b1;
    @(negedge clk); av = 1'b0; dv = 1'b0;
    chk("coincident_no_ack", tack, 1'b0);
    @(negedge clk);
    strobe_data(8'h5A);
    chk("second_data_ack", tack, 1'b1);
    split_read(16'h1010, 8'h5A, "coincident_rd");

    // Reset during SPLIT_REQ.
    strobe_addr(16'h1005, 1'b0);
    wait_req("pre_rst_req");
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_req_async", sreq, 1'b0);
    chk("rst_ready_async", trdy, 1'b1);
    @(negedge clk); rst = 1'b0;
    chk("rst_no_valid", dov, 1'b0);
    chk("rst_data_clr", dout, 8'h00);
    split_read(16'h1010, 8'h5A, "post_rst");

    // Immediate-read instance: write then read, data exactly two cycles after strobe.
    @(negedge clk); b_addr = 16'h1005; b_rw = 1'b1; b_av = 1'b1;
    @(negedge clk); b_av = 1'b0;
    @(negedge clk); b_din = 8'hA5; b_dv = 1'b1;
    @(negedge clk); b_dv = 1'b0;
    chk("imm_wr_ack", b_tack, 1'b1);
    @(negedge clk); b_rw = 1'b0; b_av = 1'b1;
    @(negedge clk); b_av = 1'b0;
    chk("imm_valid_p1", b_dov, 1'b0);
    chk("imm_no_sack", b_tsack, 1'b0);
    @(negedge clk);
    chk("imm_valid_p2", b_dov, 1'b1);
    chk("imm_ack_p2", b_tack, 1'b1);
    chk("imm_data", b_dout, 8'hA5);
    @(negedge clk);
    chk("imm_valid_1cyc", b_dov, 1'b0);
    chk("imm_ready", b_trdy, 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
